// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data-RAM port between the CPU memory stage
// (active-low nRD/nWR strobes) and a debug/loader port (req/ack).
// Each granted access holds the RAM strobes for MEM_LAT cycles, then a
// one-cycle response state releases the CPU stall or pulses dbg_ack.
module dmem_arbiter #(
    parameter int MEM_LAT = 1,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              cpu_nRD,
    input  logic              cpu_nWR,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_ack,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_nRD,
    output logic              ram_nWR,
    input  logic [DATA_W-1:0] ram_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic       OWN_CPU  = 1'b0;
    localparam logic       OWN_DBG  = 1'b1;
    localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

    state_t              state_q, state_d;
    logic                owner_q, owner_d;
    logic                last_q, last_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                we_q, we_d;
    logic                rd_q, rd_d;
    logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0]   dbg_rdata_q, dbg_rdata_d;

    logic                cpu_req;
    logic                grant_dbg;

    // A CPU access is pending whenever either strobe is low; with both low the
    // access is a write that still captures read data.
    assign cpu_req   = !cpu_nRD || !cpu_nWR;
    // Debug wins only when alone, or on a conflict when the CPU was served last.
    assign grant_dbg = dbg_req && (!cpu_req || (last_q == OWN_CPU));

    // State register and latched access; async reset also clears read data.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= IDLE;
            owner_q     <= OWN_CPU;
            last_q      <= OWN_DBG;
            cnt_q       <= 4'd0;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            rd_q        <= 1'b0;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            rd_q        <= rd_d;
            cpu_rdata_q <= cpu_rdata_d;
            dbg_rdata_q <= dbg_rdata_d;
        end
    end

    // Next-state: grant in IDLE, count down the RAM latency in ACC, one RESP cycle.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        we_d        = we_q;
        rd_d        = rd_q;
        cpu_rdata_d = cpu_rdata_q;
        dbg_rdata_d = dbg_rdata_q;
        case (state_q)
            IDLE: begin
                if (cpu_req || dbg_req) begin
                    owner_d = grant_dbg ? OWN_DBG : OWN_CPU;
                    addr_d  = grant_dbg ? dbg_addr : cpu_addr;
                    wdata_d = grant_dbg ? dbg_wdata : cpu_wdata;
                    we_d    = grant_dbg ? dbg_we : !cpu_nWR;
                    rd_d    = grant_dbg ? !dbg_we : !cpu_nRD;
                    cnt_d   = CNT_INIT;
                    state_d = ACC;
                end
            end
            ACC: begin
                if (cnt_q == 4'd0) begin
                    if (rd_q) begin
                        if (owner_q == OWN_DBG) begin
                            dbg_rdata_d = ram_rdata;
                        end else begin
                            cpu_rdata_d = ram_rdata;
                        end
                    end
                    last_d  = owner_q;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // RAM port is driven only during ACC, so reset drops the strobes at once.
    always_comb begin
        ram_nRD   = 1'b1;
        ram_nWR   = 1'b1;
        ram_addr  = '0;
        ram_wdata = '0;
        if (state_q == ACC) begin
            ram_addr  = addr_q;
            ram_wdata = wdata_q;
            if (we_q) begin
                ram_nWR = 1'b0;
            end else begin
                ram_nRD = 1'b0;
            end
        end
    end

    assign dbg_ack   = (state_q == RESP) && (owner_q == OWN_DBG);
    assign cpu_stall = cpu_req && !((state_q == RESP) && (owner_q == OWN_CPU));
    assign cpu_rdata = cpu_rdata_q;
    assign dbg_rdata = dbg_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: drives dmem_arbiter against a word RAM and checks every
// cycle against a timeline model of grants, latencies and memory contents.
module tb_dmem_arbiter;

    localparam int LAT = 3;
    localparam int AW  = 32;
    localparam int DW  = 32;

    logic          CLK = 1'b0;
    logic          RST;
    logic          cpu_nRD, cpu_nWR;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata, cpu_rdata;
    logic          cpu_stall;
    logic          dbg_req, dbg_we, dbg_ack;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_wdata, dbg_rdata;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata, ram_rdata;
    logic          ram_nRD, ram_nWR;

    logic          s_cpu_nRD;
    logic [AW-1:0] s_cpu_addr;
    logic [DW-1:0] s_cpu_rdata, s_dbg_rdata, s_ram_wdata, s_ram_rdata;
    logic [AW-1:0] s_ram_addr;
    logic          s_cpu_stall, s_dbg_ack, s_ram_nRD, s_ram_nWR;

    int vectors;
    int miscompares;
    int cyc;

    // Free-running clock.
    always #5 CLK = ~CLK;

    dmem_arbiter #(.MEM_LAT(LAT), .ADDR_W(AW), .DATA_W(DW)) u_dut (
        .CLK(CLK), .RST(RST),
        .cpu_nRD(cpu_nRD), .cpu_nWR(cpu_nWR), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_nRD(ram_nRD), .ram_nWR(ram_nWR),
        .ram_rdata(ram_rdata)
    );

    dmem_arbiter #(.MEM_LAT(1), .ADDR_W(AW), .DATA_W(DW)) u_dut_lat1 (
        .CLK(CLK), .RST(RST),
        .cpu_nRD(s_cpu_nRD), .cpu_nWR(1'b1), .cpu_addr(s_cpu_addr), .cpu_wdata(32'h0),
        .cpu_rdata(s_cpu_rdata), .cpu_stall(s_cpu_stall),
        .dbg_req(1'b0), .dbg_we(1'b0), .dbg_addr(32'h0), .dbg_wdata(32'h0),
        .dbg_ack(s_dbg_ack), .dbg_rdata(s_dbg_rdata),
        .ram_addr(s_ram_addr), .ram_wdata(s_ram_wdata), .ram_nRD(s_ram_nRD), .ram_nWR(s_ram_nWR),
        .ram_rdata(s_ram_rdata)
    );

    // Fixed-content RAM for the single-cycle-latency instance.
    assign s_ram_rdata = (s_ram_addr == 32'h10) ? 32'hDEADBEEF : 32'h0;

    // 16-word RAM: asynchronous read, write committed when the write strobe ends
    // normally, so a strobe cut short by reset never lands.
    logic [31:0] mem [16];
    logic [3:0]  wr_idx;
    logic [31:0] wr_dat;
    assign ram_rdata = mem[ram_addr[5:2]];

    // Track the address and data presented while the write strobe is low.
    always @(negedge CLK) begin
        if (!ram_nWR) begin
            wr_idx <= ram_addr[5:2];
            wr_dat <= ram_wdata;
        end
    end

    // RAM contents: random preload, then commit on each completed write strobe.
    initial begin
        for (int i = 0; i < 16; i++) mem[i] = $urandom;
        forever begin
            @(posedge ram_nWR);
            if (RST === 1'b1) mem[wr_idx] = wr_dat;
        end
    end

    // Reference model: one access in flight, described by who owns it, what it
    // does and the cycle it was granted; phases follow from elapsed cycles.
    bit          m_valid, m_owner, m_last, m_we, m_rd, m_in_resp;
    logic [31:0] m_addr, m_wdata, m_cpu_rd, m_dbg_rd;
    int          m_start;
    logic [31:0] gold [16];

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_valid   = 1'b0;
        m_in_resp = 1'b0;
        m_last    = 1'b1;
        m_cpu_rd  = 32'h0;
        m_dbg_rd  = 32'h0;
    endtask

    // Compare every DUT output against the model at mid-cycle.
    task automatic sample();
        int         k;
        bit         in_acc, creq;
        logic [3:0] idx;
        @(negedge CLK);
        k         = cyc - m_start;
        in_acc    = m_valid && (k >= 1) && (k <= LAT);
        m_in_resp = m_valid && (k == LAT + 1);
        if (m_in_resp) begin
            idx = m_addr[5:2];
            if (m_rd) begin
                if (m_owner) m_dbg_rd = gold[idx];
                else         m_cpu_rd = gold[idx];
            end
            if (m_we) gold[idx] = m_wdata;
        end
        creq = !cpu_nRD || !cpu_nWR;
        check_output("ram_nRD", 32'(ram_nRD), 32'(!(in_acc && !m_we)));
        check_output("ram_nWR", 32'(ram_nWR), 32'(!(in_acc && m_we)));
        check_output("ram_addr", ram_addr, in_acc ? m_addr : 32'h0);
        check_output("ram_wdata", ram_wdata, in_acc ? m_wdata : 32'h0);
        check_output("dbg_ack", 32'(dbg_ack), 32'(m_in_resp && m_owner));
        check_output("cpu_stall", 32'(cpu_stall), 32'(creq && !(m_in_resp && !m_owner)));
        check_output("cpu_rdata", cpu_rdata, m_cpu_rd);
        check_output("dbg_rdata", dbg_rdata, m_dbg_rd);
    endtask

    // Close the cycle: retire a finished access or arbitrate a new one.
    task automatic advance();
        bit creq, dreq, gd;
        creq = !cpu_nRD || !cpu_nWR;
        dreq = dbg_req;
        if (m_in_resp) begin
            m_valid = 1'b0;
            m_last  = m_owner;
        end else if (!m_valid && (creq || dreq)) begin
            gd      = dreq && (!creq || !m_last);
            m_owner = gd;
            m_addr  = gd ? dbg_addr : cpu_addr;
            m_wdata = gd ? dbg_wdata : cpu_wdata;
            m_we    = gd ? dbg_we : !cpu_nWR;
            m_rd    = gd ? !dbg_we : !cpu_nRD;
            m_start = cyc;
            m_valid = 1'b1;
        end
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    task automatic drive_idle();
        cpu_nRD = 1'b1; cpu_nWR = 1'b1; cpu_addr = 32'h0; cpu_wdata = 32'h0;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = 32'h0; dbg_wdata = 32'h0;
    endtask

    // Present one CPU and/or debug request from relative cycle 0, drop each
    // the cycle after its response, and report response cycles and strobes.
    task automatic apply_stimulus(input bit c_go, input bit c_nrd, input bit c_nwr,
                                  input logic [31:0] c_a, input logic [31:0] c_d,
                                  input bit d_go, input bit d_we,
                                  input logic [31:0] d_a, input logic [31:0] d_d,
                                  output int c_resp, output int d_resp,
                                  output logic [31:0] first_addr,
                                  output int nwr_low, output int nrd_low,
                                  output bit stall_at_ack);
        bit c_pend, d_pend, seen;
        int r;
        c_pend = c_go; d_pend = d_go; seen = 1'b0;
        c_resp = -1; d_resp = -1; first_addr = 32'hFFFF_FFFF;
        nwr_low = 0; nrd_low = 0; stall_at_ack = 1'b0;
        r = 0;
        while ((c_pend || d_pend) && r < 40) begin
            cpu_nRD   = c_pend ? c_nrd : 1'b1;
            cpu_nWR   = c_pend ? c_nwr : 1'b1;
            cpu_addr  = c_pend ? c_a : 32'h0;
            cpu_wdata = c_pend ? c_d : 32'h0;
            dbg_req   = d_pend;
            dbg_we    = d_pend ? d_we : 1'b0;
            dbg_addr  = d_pend ? d_a : 32'h0;
            dbg_wdata = d_pend ? d_d : 32'h0;
            sample();
            if ((!ram_nRD || !ram_nWR) && !seen) begin
                seen = 1'b1;
                first_addr = ram_addr;
            end
            if (!ram_nWR) nwr_low++;
            if (!ram_nRD) nrd_low++;
            if (c_pend && !cpu_stall) begin c_resp = r; c_pend = 1'b0; end
            if (d_pend && dbg_ack) begin d_resp = r; d_pend = 1'b0; stall_at_ack = cpu_stall; end
            advance();
            r++;
        end
        if (c_pend || d_pend) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL response_timeout: got no response within 40 cycles, expected one");
        end
        drive_idle();
        sample();
        advance();
    endtask

    int          c_resp, d_resp, nwr_low, nrd_low;
    logic [31:0] first_addr, pre_word;
    bit          stall_at_ack;
    bit          c_on, c_got, d_on, d_got;
    int          op;

    initial begin
        vectors = 0; miscompares = 0; cyc = 0;
        model_reset();
        RST = 1'b0;
        drive_idle();
        cpu_nRD = 1'b0;
        s_cpu_nRD = 1'b1; s_cpu_addr = 32'h0;
        repeat (2) @(posedge CLK);

        // Reset values, with a CPU read strobe held low during reset.
        @(negedge CLK);
        check_output("rst_ram_nRD", 32'(ram_nRD), 32'd1);
        check_output("rst_ram_nWR", 32'(ram_nWR), 32'd1);
        check_output("rst_ram_addr", ram_addr, 32'h0);
        check_output("rst_ram_wdata", ram_wdata, 32'h0);
        check_output("rst_cpu_rdata", cpu_rdata, 32'h0);
        check_output("rst_dbg_rdata", dbg_rdata, 32'h0);
        check_output("rst_dbg_ack", 32'(dbg_ack), 32'd0);
        check_output("rst_cpu_stall_req", 32'(cpu_stall), 32'd1);
        cpu_nRD = 1'b1;
        #1;
        check_output("rst_cpu_stall_noreq", 32'(cpu_stall), 32'd0);
        for (int i = 0; i < 16; i++) gold[i] = mem[i];
        @(posedge CLK);
        #1;
        RST = 1'b1;
        cyc = 0;

        // MEM_LAT=1 instance: CPU read of 0x10.
        for (int r = 0; r < 4; r++) begin
            s_cpu_nRD  = (r <= 2) ? 1'b0 : 1'b1;
            s_cpu_addr = 32'h10;
            sample();
            check_output("lat1_ram_nRD", 32'(s_ram_nRD), (r == 1) ? 32'd0 : 32'd1);
            if (r <= 2) check_output("lat1_cpu_stall", 32'(s_cpu_stall), (r == 2) ? 32'd0 : 32'd1);
            if (r >= 2) check_output("lat1_cpu_rdata", s_cpu_rdata, 32'hDEADBEEF);
            advance();
        end
        s_cpu_nRD = 1'b1;

        // Simultaneous requests right after reset: CPU first.
        apply_stimulus(1'b1, 1'b0, 1'b1, 32'h40, 32'h0, 1'b1, 1'b0, 32'h44, 32'h0,
                       c_resp, d_resp, first_addr, nwr_low, nrd_low, stall_at_ack);
        check_output("conflict1_first_addr", first_addr, 32'h40);
        check_output("conflict1_cpu_resp", 32'(c_resp), 32'd4);
        check_output("conflict1_dbg_resp", 32'(d_resp), 32'd9);

        // Lone CPU write makes the CPU the last winner.
        apply_stimulus(1'b1, 1'b1, 1'b0, 32'h08, 32'h11111111, 1'b0, 1'b0, 32'h0, 32'h0,
                       c_resp, d_resp, first_addr, nwr_low, nrd_low, stall_at_ack);
        check_output("cpu_write_resp", 32'(c_resp), 32'd4);

        // Simultaneous again: debug first, CPU stays stalled through its ack.
        apply_stimulus(1'b1, 1'b0, 1'b1, 32'h08, 32'h0, 1'b1, 1'b0, 32'h0C, 32'h0,
                       c_resp, d_resp, first_addr, nwr_low, nrd_low, stall_at_ack);
        check_output("conflict2_first_addr", first_addr, 32'h0C);
        check_output("conflict2_dbg_resp", 32'(d_resp), 32'd4);
        check_output("conflict2_stall_at_ack", 32'(stall_at_ack), 32'd1);
        check_output("conflict2_cpu_resp", 32'(c_resp), 32'd9);
        check_output("conflict2_cpu_rdata", cpu_rdata, 32'h11111111);

        // Debug write then read back of 0x20.
        apply_stimulus(1'b0, 1'b1, 1'b1, 32'h0, 32'h0, 1'b1, 1'b1, 32'h20, 32'h12345678,
                       c_resp, d_resp, first_addr, nwr_low, nrd_low, stall_at_ack);
        check_output("dbg_write_nwr_cycles", 32'(nwr_low), 32'd3);
        check_output("dbg_write_ack", 32'(d_resp), 32'd4);
        apply_stimulus(1'b0, 1'b1, 1'b1, 32'h0, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0,
                       c_resp, d_resp, first_addr, nwr_low, nrd_low, stall_at_ack);
        check_output("dbg_read_rdata", dbg_rdata, 32'h12345678);

        // CPU with both strobes low performs a write.
        apply_stimulus(1'b1, 1'b0, 1'b0, 32'h24, 32'hA5A5A5A5, 1'b0, 1'b0, 32'h0, 32'h0,
                       c_resp, d_resp, first_addr, nwr_low, nrd_low, stall_at_ack);
        check_output("both_low_nwr_cycles", 32'(nwr_low), 32'd3);
        check_output("both_low_nrd_cycles", 32'(nrd_low), 32'd0);
        check_output("both_low_cpu_resp", 32'(c_resp), 32'd4);
        check_output("both_low_mem", mem[9], 32'hA5A5A5A5);

        // Reset pulsed in the second ACC cycle of a debug write to 0x30.
        pre_word = mem[12];
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h30; dbg_wdata = 32'hCAFEF00D;
        sample();
        advance();
        sample();
        check_output("abort_acc1_nWR", 32'(ram_nWR), 32'd0);
        advance();
        #1;
        RST = 1'b0;
        #1;
        check_output("abort_nWR_released", 32'(ram_nWR), 32'd1);
        check_output("abort_addr_cleared", ram_addr, 32'h0);
        drive_idle();
        model_reset();
        @(negedge CLK);
        check_output("abort_no_ack", 32'(dbg_ack), 32'd0);
        check_output("abort_dbg_rdata", dbg_rdata, 32'h0);
        check_output("abort_cpu_rdata", cpu_rdata, 32'h0);
        @(posedge CLK);
        #1;
        RST = 1'b1;
        cyc++;
        for (int i = 0; i < 5; i++) begin
            sample();
            advance();
        end
        check_output("abort_mem_unchanged", mem[12], pre_word);

        // Randomized traffic from both requesters.
        c_on = 1'b0; c_got = 1'b0; d_on = 1'b0; d_got = 1'b0;
        for (int t = 0; t < 3000; t++) begin
            if (c_got) begin
                c_on = 1'b0; c_got = 1'b0; cpu_nRD = 1'b1; cpu_nWR = 1'b1;
            end else if (!c_on && $urandom_range(0, 2) == 0) begin
                c_on = 1'b1;
                op = $urandom_range(0, 2);
                cpu_nRD   = (op == 1);
                cpu_nWR   = (op == 0);
                cpu_addr  = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
                cpu_wdata = $urandom;
            end
            if (d_got) begin
                d_on = 1'b0; d_got = 1'b0; dbg_req = 1'b0;
            end else if (!d_on && $urandom_range(0, 2) == 0) begin
                d_on = 1'b1;
                dbg_req   = 1'b1;
                dbg_we    = 1'($urandom_range(0, 1));
                dbg_addr  = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
                dbg_wdata = $urandom;
            end
            sample();
            if (c_on && !cpu_stall) c_got = 1'b1;
            if (d_on && dbg_ack) d_got = 1'b1;
            advance();
        end
        drive_idle();
        for (int i = 0; i < 2 * (LAT + 2); i++) begin
            sample();
            advance();
        end

        // RAM contents must match every write the model retired.
        for (int i = 0; i < 16; i++) check_output("mem_final", mem[i], gold[i]);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter and access sequencer for the shared data RAM of the multicycle CPU. It multiplexes the CPU's memory-stage accesses (active-low nRD/nWR strobes) and a debug/loader port (req/ack handshake) onto the single RAM port. It holds each granted access for a configurable RAM latency and returns registered read data. It stalls the CPU while the CPU's access is pending, so the control unit holds its current state.

## Interface
- MEM_LAT, 1: cycles the RAM strobes are held per access; legal range 1..15
- ADDR_W, 32: address width
- DATA_W, 32: data width

- CLK  in  1  system clock; all state updates on rising edge
- RST  in  1  reset, asynchronous, active-low
- cpu_nRD  in  1  CPU read strobe, active-low
- cpu_nWR  in  1  CPU write strobe, active-low
- cpu_addr  in  ADDR_W  CPU byte address (ALU result)
- cpu_wdata  in  DATA_W  CPU write data (B register)
- cpu_rdata  out  DATA_W  registered read data for the CPU
- cpu_stall  out  1  high while a CPU request is pending and not yet responded
- dbg_req  in  1  debug request, level, held until dbg_ack
- dbg_we  in  1  1 = write, 0 = read
- dbg_addr  in  ADDR_W  debug address
- dbg_wdata  in  DATA_W  debug write data
- dbg_ack  out  1  one-cycle completion pulse
- dbg_rdata  out  DATA_W  registered read data for debug
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  DATA_W  RAM write data
- ram_nRD  out  1  RAM read strobe, active-low
- ram_nWR  out  1  RAM write strobe, active-low
- ram_rdata  in  DATA_W  RAM read data

## Operation
- cpu_req = !cpu_nRD | !cpu_nWR. If both strobes are low, the access is a write; the read data is still captured.
- FSM states: IDLE, ACC, RESP. There is one `owner` register (CPU/DBG) and one `last` register holding the last granted requester.
- IDLE:
  - Only one request present: grant it.
  - Both present: grant the requester that is not `last` (round-robin).
  - On grant: latch owner, address, wdata and op into internal registers. Load the counter with MEM_LAT-1 and go to ACC.
- ACC:
  - Drive ram_addr/ram_wdata from the latched registers.
  - Write: ram_nWR=0. Read: ram_nRD=0.
  - Decrement the counter each cycle. When the counter is 0, capture ram_rdata into the owner's rdata register, set last=owner and go to RESP.
- RESP:
  - CPU owner: cpu_stall=0 this cycle. DBG owner: dbg_ack=1 this cycle.
  - Go to IDLE unconditionally.
- cpu_stall = cpu_req & !(state==RESP & owner==CPU). The CPU is stalled in IDLE and in ACC, including while a DBG access is in flight.
- Requesters hold addr/data/strobes stable until their response. A request still asserted in IDLE after its response is a new request, so requesters deassert on the cycle after the response.
- Outside ACC: ram_nRD=ram_nWR=1, ram_addr=0, ram_wdata=0.
- The non-owning rdata register holds its value. rdata is only overwritten for reads and for the both-strobes-low CPU case.

## Timing
- Reset values:
  - state=IDLE, last=DBG (the CPU wins the first conflict), owner=CPU, counter=0.
  - cpu_rdata=0, dbg_rdata=0, dbg_ack=0.
  - ram_nRD=ram_nWR=1, ram_addr=0, ram_wdata=0.
  - cpu_stall follows its equation (high if cpu_req is asserted during reset).
- Uncontended latency: request seen in IDLE at cycle 0 → ACC in cycles 1..MEM_LAT → RESP at cycle MEM_LAT+1. Read data is valid in RESP and stays until the next read by the same owner.
- Contended: the loser waits one full access (MEM_LAT+2 cycles) plus its own access.
- Back-to-back throughput is one access per MEM_LAT+2 cycles. RESP always returns to IDLE.
- Reset asserted mid-ACC forces the strobes inactive immediately (asynchronously). The write is aborted, no ack is issued, and rdata is cleared.
- A request dropped during ACC does not abort the access; RESP is still produced.
- dbg_req asserted during RESP is not sampled until IDLE.

## Test plan
- MEM_LAT=1: CPU read of addr 0x10 (RAM holds 0xDEADBEEF).
  - ram_nRD low in cycle 1 only.
  - cpu_stall high in cycles 0–1, low in cycle 2.
  - cpu_rdata=0xDEADBEEF in cycle 2.
- MEM_LAT=3: dbg write of 0x12345678 to 0x20, then dbg read of 0x20.
  - ram_nWR low for exactly 3 cycles.
  - First dbg_ack at cycle 4.
  - Read returns dbg_rdata=0x12345678.
- Both request in the same IDLE cycle after reset: CPU is granted first, DBG second.
- Repeat the simultaneous request with DBG granted first (last=CPU): DBG is granted, cpu_stall stays high through the DBG RESP.
- RST pulsed low in the 2nd ACC cycle of a MEM_LAT=3 dbg write:
  - ram_nWR returns to 1 within the same cycle.
  - No dbg_ack.
  - RAM word at the target address is unchanged.
- CPU asserts both strobes with cpu_wdata=0xA5A5A5A5: a write is performed (ram_nWR=0, ram_nRD=1) and cpu_stall is released in RESP.
